vec_state_mover: RTL and testbench

VEC_STATE_MOVER -- requirements
Module: vec_state_mover

---
 rtl/vec_state_mover.sv | 142 ++++++++++++++
 tb/tb_vec_state_mover.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vec_state_mover.sv
// Moves one 4-word AES state block between a 32-bit word stream and a 16-row register file,
// as columns of a 4-row block (TRANSPOSE=1) or as four consecutive rows (TRANSPOSE=0).
module vec_state_mover #(
  parameter bit TRANSPOSE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        dir,
  input  logic [3:0]  base,
  output logic        busy,
  output logic        done,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        rf_wr_en,
  output logic        rf_col_write,
  output logic [1:0]  rf_columnaw,
  output logic [3:0]  rf_write_addr,
  output logic [31:0] rf_wdata,
  output logic        rf_col_read,
  output logic [1:0]  rf_columnar,
  output logic [3:0]  rf_fila1,
  input  logic [31:0] rf_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STORE, S_FINISH} state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_base;
  logic [1:0]  r_k;
  logic        r_k_full;
  logic        r_wr_pend;
  logic [31:0] r_wr_data;
  logic [1:0]  r_wr_k;
  logic        r_out_valid;
  logic [31:0] r_out_data;

  logic        w_accept;
  logic        w_out_load;
  logic [3:0]  w_wr_row;
  logic [3:0]  w_rd_row;

  // Row arithmetic is 4 bits wide, so base+k wraps modulo 16 by construction.
  assign w_wr_row   = r_base + {2'b00, r_wr_k};
  assign w_rd_row   = r_base + {2'b00, r_k};
  assign w_accept   = in_valid & in_ready;
  assign w_out_load = (r_state == S_STORE) && !r_k_full && (!r_out_valid || out_ready);

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign rf_wdata  = r_wr_data;

  // NOTE: every signal driven here gets a default first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    w_next        = r_state;
    busy          = (r_state != S_IDLE);
    done          = 1'b0;
    in_ready      = 1'b0;
    rf_wr_en      = 1'b0;
    rf_col_write  = 1'b0;
    rf_columnaw   = 2'b00;
    rf_write_addr = 4'h0;
    rf_col_read   = 1'b0;
    rf_columnar   = 2'b00;
    rf_fila1      = 4'h0;

    case (r_state)
      S_IDLE: begin
        if (start) w_next = dir ? S_STORE : S_LOAD;
      end
      S_LOAD: begin
        in_ready = !r_k_full;
        // The write of the 4th accepted word is the last LOAD cycle.
        if (r_wr_pend && r_k_full) w_next = S_FINISH;
      end
      S_STORE: begin
        rf_col_read = TRANSPOSE;
        rf_columnar = TRANSPOSE ? r_k : 2'b00;
        rf_fila1    = TRANSPOSE ? r_base : w_rd_row;
        if (r_out_valid && out_ready && r_k_full) w_next = S_FINISH;
      end
      S_FINISH: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase

    if (r_wr_pend) begin
      rf_wr_en      = 1'b1;
      rf_col_write  = TRANSPOSE;
      rf_columnaw   = TRANSPOSE ? r_wr_k : 2'b00;
      rf_write_addr = TRANSPOSE ? r_base : w_wr_row;
    end
  end

  // NOTE: state registers use non-blocking assignments so each one samples the values from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_base      <= 4'h0;
      r_k         <= 2'b00;
      r_k_full    <= 1'b0;
      r_wr_pend   <= 1'b0;
      r_wr_data   <= 32'h0;
      r_wr_k      <= 2'b00;
      r_out_valid <= 1'b0;
      r_out_data  <= 32'h0;
    end else begin
      r_state   <= w_next;
      r_wr_pend <= w_accept;

      if (r_state == S_IDLE && start) begin
        r_base   <= base;
        r_k      <= 2'b00;
        r_k_full <= 1'b0;
      end else if (w_accept || w_out_load) begin
        r_k <= r_k + 2'd1;
        if (r_k == 2'd3) r_k_full <= 1'b1;
      end

      if (w_accept) begin
        r_wr_data <= in_data;
        r_wr_k    <= r_k;
      end

      // One-deep output register: refill on empty or on the handshake that drains it.
      if (w_out_load) begin
        r_out_valid <= 1'b1;
        r_out_data  <= rf_rdata;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_state_mover.sv
// Scoreboard bench for vec_state_mover: a column-mode instance backed by a register-file
// model, plus a row-mode instance for wrap-around row writes.
module tb_vec_state_mover;

  typedef struct packed {
    logic [31:0] data;
    logic        col;
    logic [1:0]  cidx;
    logic [3:0]  addr;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n, start, start_b, dir, in_valid, out_ready;
  logic [3:0]  base;
  logic [31:0] in_data, rf_rdata;

  logic        busy_a, done_a, in_ready_a, out_valid_a, rf_wr_en_a, rf_col_write_a, rf_col_read_a;
  logic [31:0] out_data_a, rf_wdata_a;
  logic [1:0]  rf_columnaw_a, rf_columnar_a;
  logic [3:0]  rf_write_addr_a, rf_fila1_a;

  logic        busy_b, done_b, in_ready_b, out_valid_b, rf_wr_en_b, rf_col_write_b, rf_col_read_b;
  logic [31:0] out_data_b, rf_wdata_b;
  logic [1:0]  rf_columnaw_b, rf_columnar_b;
  logic [3:0]  rf_write_addr_b, rf_fila1_b;

  logic [31:0] rf_mem [16];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          done_cnt = 0;
  logic        use_b;

  wr_t         exp_wr_q [$];
  logic [31:0] exp_out_q [$];
  int          acc_q [$];
  int          hs_q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vec_state_mover #(.TRANSPOSE(1'b1)) u_dut_col (
    .clk(clk), .rst_n(rst_n), .start(start), .dir(dir), .base(base),
    .busy(busy_a), .done(done_a),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .rf_wr_en(rf_wr_en_a), .rf_col_write(rf_col_write_a), .rf_columnaw(rf_columnaw_a),
    .rf_write_addr(rf_write_addr_a), .rf_wdata(rf_wdata_a),
    .rf_col_read(rf_col_read_a), .rf_columnar(rf_columnar_a), .rf_fila1(rf_fila1_a),
    .rf_rdata(rf_rdata)
  );

  vec_state_mover #(.TRANSPOSE(1'b0)) u_dut_row (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dir(dir), .base(base),
    .busy(busy_b), .done(done_b),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .rf_wr_en(rf_wr_en_b), .rf_col_write(rf_col_write_b), .rf_columnaw(rf_columnaw_b),
    .rf_write_addr(rf_write_addr_b), .rf_wdata(rf_wdata_b),
    .rf_col_read(rf_col_read_b), .rf_columnar(rf_columnar_b), .rf_fila1(rf_fila1_b),
    .rf_rdata(32'h0)
  );

  // Register file: 16 rows of 4 bytes, column 0 in the most significant byte.
  always @(posedge clk) begin
    if (rf_wr_en_a) begin
      if (rf_col_write_a) begin
        for (int j = 0; j < 4; j++)
          rf_mem[rf_write_addr_a + 4'(j)][31-8*int'(rf_columnaw_a) -: 8] <= rf_wdata_a[31-8*j -: 8];
      end else begin
        rf_mem[rf_write_addr_a] <= rf_wdata_a;
      end
    end
  end

  always_comb begin
    rf_rdata = 32'h0;
    if (rf_col_read_a) begin
      for (int j = 0; j < 4; j++)
        rf_rdata[31-8*j -: 8] = rf_mem[rf_fila1_a + 4'(j)][31-8*int'(rf_columnar_a) -: 8];
    end else begin
      rf_rdata = rf_mem[rf_fila1_a];
    end
  end

  logic        mon_busy, mon_done, mon_in_ready, mon_wr_en, mon_col_write, mon_out_valid;
  logic [31:0] mon_wdata, mon_out_data;
  logic [1:0]  mon_columnaw;
  logic [3:0]  mon_write_addr;

  always_comb begin
    mon_busy       = use_b ? busy_b          : busy_a;
    mon_done       = use_b ? done_b          : done_a;
    mon_in_ready   = use_b ? in_ready_b      : in_ready_a;
    mon_wr_en      = use_b ? rf_wr_en_b      : rf_wr_en_a;
    mon_col_write  = use_b ? rf_col_write_b  : rf_col_write_a;
    mon_columnaw   = use_b ? rf_columnaw_b   : rf_columnaw_a;
    mon_write_addr = use_b ? rf_write_addr_b : rf_write_addr_a;
    mon_wdata      = use_b ? rf_wdata_b      : rf_wdata_a;
    mon_out_valid  = use_b ? out_valid_b     : out_valid_a;
    mon_out_data   = use_b ? out_data_b      : out_data_a;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor on the falling edge, away from the sampling edge of the DUT.
  logic        prev_stall = 1'b0;
  logic        prev_done  = 1'b0;
  logic [31:0] prev_data  = 32'h0;
  wr_t         g_wr, e_wr;
  int          a_cyc;

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && mon_in_ready) acc_q.push_back(cyc);
      if (mon_wr_en) begin
        check("wr_vs_out", 64'(mon_out_valid), 64'd0);
        g_wr.data = mon_wdata;
        g_wr.col  = mon_col_write;
        g_wr.cidx = mon_col_write ? mon_columnaw : 2'b00;
        g_wr.addr = mon_write_addr;
        if (exp_wr_q.size() == 0) begin
          check("wr_extra", 64'(g_wr), 64'd0);
        end else begin
          e_wr = exp_wr_q.pop_front();
          check("wr_fields", 64'(g_wr), 64'(e_wr));
          a_cyc = (acc_q.size() > 0) ? acc_q.pop_front() : -100;
          check("wr_latency", 64'(cyc - a_cyc), 64'd1);
        end
      end
      if (prev_stall) check("out_hold", 64'({mon_out_valid, mon_out_data}), 64'({1'b1, prev_data}));
      if (mon_out_valid && out_ready) begin
        if (exp_out_q.size() == 0) check("out_extra", 64'(mon_out_data), 64'd0);
        else check("out_data", 64'(mon_out_data), 64'(exp_out_q.pop_front()));
        hs_q.push_back(cyc);
      end
      if (mon_done) begin
        done_cnt++;
        check("done_1cyc", 64'(prev_done), 64'd0);
      end
      prev_stall = mon_out_valid && !out_ready;
      prev_data  = mon_out_data;
      prev_done  = mon_done;
    end else begin
      prev_stall = 1'b0;
      prev_done  = 1'b0;
    end
  end

  task automatic wait_done(input int d0, input int budget);
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("done_seen", 64'(done_cnt != d0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_once", 64'(done_cnt - d0), 64'd1);
    check("idle_after", 64'(mon_busy), 64'd0);
  endtask

  task automatic run_load(input bit b_inst, input logic [3:0] b, input logic [3:0][31:0] words,
                          input logic [3:0][7:0] offs, input bit intrude);
    wr_t e;
    int  d0, idx;
    use_b = b_inst;
    for (int k = 0; k < 4; k++) begin
      e.data = words[k];
      e.col  = !b_inst;
      e.cidx = b_inst ? 2'b00 : 2'(k);
      e.addr = b_inst ? b + 4'(k) : b;
      exp_wr_q.push_back(e);
    end
    d0 = done_cnt;
    @(posedge clk); #1;
    if (b_inst) start_b = 1'b1; else start = 1'b1;
    dir  = 1'b0;
    base = b;
    @(posedge clk); #1;
    start = 1'b0; start_b = 1'b0;
    dir   = 1'b1; base = 4'hF;  // must be ignored while busy
    check("load_busy", 64'(mon_busy), 64'd1);
    check("in_ready_on", 64'(mon_in_ready), 64'd1);
    idx = 0;
    for (int t = 0; idx < 4; t++) begin
      if (t == int'(offs[idx])) begin
        in_valid = 1'b1; in_data = words[idx]; idx++;
      end else begin
        in_valid = 1'b0; in_data = 32'hBAD00000 | 32'(t);
      end
      if (intrude && t == 1) begin start = 1'b1; dir = 1'b1; base = 4'd8; end
      else start = 1'b0;
      @(posedge clk); #1;
    end
    start = 1'b0;
    check("in_ready_off", 64'(mon_in_ready), 64'd0);
    in_valid = 1'b1; in_data = 32'hDEADBEEF;  // no 5th word may be taken
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_done(d0, 20);
    check("wr_q_empty", 64'(exp_wr_q.size()), 64'd0);
    acc_q.delete();
    dir = 1'b0; base = 4'h0;
  endtask

  task automatic run_store(input logic [3:0] b, input logic [3:0][31:0] words, input bit toggle);
    int d0, c0;
    use_b = 1'b0;
    for (int k = 0; k < 4; k++) exp_out_q.push_back(words[k]);
    hs_q.delete();
    d0 = done_cnt;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b1; base = b;
    c0 = cyc;
    @(posedge clk); #1;
    start = 1'b0; dir = 1'b0; base = 4'h0;
    for (int n = 0; n < 40 && done_cnt == d0; n++) begin
      @(posedge clk); #1;
      if (toggle) out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    wait_done(d0, 5);
    check("out_q_empty", 64'(exp_out_q.size()), 64'd0);
    if (!toggle) begin
      check("hs_cnt", 64'(hs_q.size()), 64'd4);
      if (hs_q.size() == 4) begin
        check("hs_first", 64'(hs_q[0] - c0), 64'd2);
        check("hs_burst", 64'(hs_q[3] - hs_q[0]), 64'd3);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [3:0][31:0] w1, w2;
  logic [3:0][7:0]  offs_seq, offs_gap;
  int               d0;
  wr_t              e0;

  initial begin
    rst_n = 1'b0; start = 1'b0; start_b = 1'b0; dir = 1'b0; base = 4'h0;
    in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b0; use_b = 1'b0;
    w1 = {32'hCCDDEEFF, 32'h8899AABB, 32'h44556677, 32'h00112233};
    w2 = {32'hD0D1D2D3, 32'hC0C1C2C3, 32'hB0B1B2B3, 32'hA0A1A2A3};
    offs_seq = {8'd3, 8'd2, 8'd1, 8'd0};
    offs_gap = {8'd9, 8'd4, 8'd3, 8'd0};

    @(posedge clk); #1;
    check("rst_ctl_a", 64'({busy_a, done_a, in_ready_a, out_valid_a, rf_wr_en_a, rf_col_write_a, rf_col_read_a}), 64'd0);
    check("rst_dat_a", 64'({out_data_a, rf_wdata_a}), 64'd0);
    check("rst_adr_a", 64'({rf_columnaw_a, rf_write_addr_a, rf_columnar_a, rf_fila1_a}), 64'd0);
    check("rst_all_b", 64'({busy_b, done_b, in_ready_b, out_valid_b, rf_wr_en_b, rf_col_write_b, rf_col_read_b,
                            rf_columnaw_b, rf_write_addr_b, rf_columnar_b, rf_fila1_b, |out_data_b, |rf_wdata_b}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; out_ready = 1'b1;

    run_load(1'b0, 4'd4, w1, offs_seq, 1'b0);
    check("rf_row4", 64'(rf_mem[4]), 64'h004488CC);
    run_store(4'd4, w1, 1'b1);
    run_store(4'd4, w1, 1'b0);
    run_load(1'b1, 4'd14, w2, offs_seq, 1'b0);
    run_load(1'b0, 4'd2, w2, offs_seq, 1'b1);
    run_load(1'b0, 4'd10, w1, offs_gap, 1'b0);

    // Reset right after the 2nd word is accepted: only the 1st write may reach the register file.
    use_b = 1'b0;
    d0 = done_cnt;
    e0.data = w2[0]; e0.col = 1'b1; e0.cidx = 2'b00; e0.addr = 4'h0;
    exp_wr_q.push_back(e0);
    @(posedge clk); #1;
    start = 1'b1; dir = 1'b0; base = 4'h0;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; in_data = w2[0];
    @(posedge clk); #1;
    in_data = w2[1];
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0;
    #1;
    check("mid_rst_ctl", 64'({busy_a, done_a, in_ready_a, out_valid_a, rf_wr_en_a, rf_col_write_a, rf_col_read_a}), 64'd0);
    check("mid_rst_dat", 64'({out_data_a, rf_wdata_a}), 64'd0);
    check("mid_rst_adr", 64'({rf_columnaw_a, rf_write_addr_a, rf_columnar_a, rf_fila1_a}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("mid_rst_nowr", 64'(rf_wr_en_a), 64'd0);
    rst_n = 1'b1;
    acc_q.delete();
    check("mid_rst_q", 64'(exp_wr_q.size()), 64'd0);
    check("mid_rst_nodone", 64'(done_cnt - d0), 64'd0);
    run_load(1'b0, 4'd8, w2, offs_seq, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
